tt_um_count_sequencer: RTL

Sweep controller for the 4-bit up/down counter datapath. It latches a low/high limit window, a sweep mode and a step prescaler at a start command, then sequences the counter through the window. It reports position, direction, busy, done and a configuration error on the dedicated outputs. The block is a standard Tiny Tapeout user top, so it occupies the same slot and pin set as the plain counter.

---
 rtl/tt_um_count_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/tt_um_count_sequencer.sv
// Sweep controller for the 4-bit up/down counter datapath.
// Latches a lo/hi window, sweep mode and step prescaler on a start edge, then
// steps the counter through the window until it finishes or is stopped.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   ena         : powered indicator (unused)
//   ui_in       : [0] start (rising edge), [1] stop, [3:2] mode, [7:4] prescale
//   uio_in      : [3:0] lo limit, [7:4] hi limit (sampled at accepted start)
//   uo_out      : [3:0] count, [4] dir, [5] busy, [6] done, [7] err
//   uio_out     : constant 0
//   uio_oe      : constant 0 (all bidirectionals are inputs)
module tt_um_count_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CW = 4;
  localparam int unsigned MW = 2;

  localparam logic [MW-1:0] MODE_UP_ONCE   = 2'b00;
  localparam logic [MW-1:0] MODE_DOWN_ONCE = 2'b01;
  localparam logic [MW-1:0] MODE_PINGPONG  = 2'b10;
  localparam logic [MW-1:0] MODE_UP_WRAP   = 2'b11;

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic            start_q;
  logic [CW-1:0]   count_q, count_d;
  logic            dir_q, dir_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [CW-1:0]   lo_q, lo_d;
  logic [CW-1:0]   hi_q, hi_d;
  logic [MW-1:0]   mode_q, mode_d;
  logic [CW-1:0]   p_q, p_d;
  logic [CW-1:0]   pre_q, pre_d;

  logic            start_edge_c;
  logic            stop_c;
  logic            tick_c;
  logic [CW-1:0]   inc_c;
  logic [CW-1:0]   dec_c;
  logic            unused_ena_c;

  assign unused_ena_c = ena;
  assign start_edge_c = ui_in[0] & ~start_q;
  assign stop_c       = ui_in[1];
  assign tick_c       = (pre_q == p_q);
  assign inc_c        = count_q + CW'(1);
  assign dec_c        = count_q - CW'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      count_q <= '0;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= '0;
      p_q     <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= ui_in[0];
      count_q <= count_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      pre_q   <= pre_d;
    end
  end

  // Next-state: start acceptance, prescaled stepping, finish and stop
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mode_d  = mode_q;
    p_d     = p_q;
    pre_d   = pre_q;

    case (state_q)
      IDLE: begin
        // stop masks a coincident start edge
        if (start_edge_c && !stop_c) begin
          if (uio_in[3:0] > uio_in[7:4]) begin
            err_d = 1'b1;
          end else begin
            lo_d    = uio_in[3:0];
            hi_d    = uio_in[7:4];
            mode_d  = ui_in[3:2];
            p_d     = ui_in[7:4];
            pre_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
            if (ui_in[3:2] == MODE_DOWN_ONCE) begin
              count_d = uio_in[7:4];
              dir_d   = 1'b0;
            end else begin
              count_d = uio_in[3:0];
              dir_d   = 1'b1;
            end
          end
        end
      end

      RUN: begin
        if (stop_c) begin
          // stop beats any step or finish on the same edge
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          pre_d = tick_c ? '0 : pre_q + CW'(1);
          if (tick_c) begin
            case (mode_q)
              MODE_UP_ONCE: begin
                if (count_q != hi_q) count_d = inc_c;
                if (count_q == hi_q || inc_c == hi_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                end
              end
              MODE_DOWN_ONCE: begin
                if (count_q != lo_q) count_d = dec_c;
                if (count_q == lo_q || dec_c == lo_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                end
              end
              MODE_PINGPONG: begin
                // turn at a limit and step away in the same tick
                if (dir_q) begin
                  if (count_q == hi_q) begin
                    dir_d   = 1'b0;
                    count_d = (lo_q == hi_q) ? count_q : dec_c;
                  end else begin
                    count_d = inc_c;
                  end
                end else begin
                  if (count_q == lo_q) begin
                    dir_d   = 1'b1;
                    count_d = (lo_q == hi_q) ? count_q : inc_c;
                  end else begin
                    count_d = dec_c;
                  end
                end
              end
              MODE_UP_WRAP: begin
                count_d = (count_q == hi_q) ? lo_q : inc_c;
              end
              default: ;
            endcase
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign uo_out  = {err_q, done_q, busy_q, dir_q, count_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule
